pc: RTL and testbench
=====================

PC -- requirements
Module: pc

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h00000000, PC value forced while the boot flag is set.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h00000080, exception handler entry address.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port present_pc, input, 32, address of the current instruction.
REQ-006 SHALL have port extend_inst, input, 32, sign-extended 16-bit branch offset, in words.
REQ-007 SHALL have port instr, input, 32, current instruction; bits [25:0] are the J-type index.
REQ-008 SHALL have port regfile_r1, input, 32, rs register value used as the JR target.
REQ-009 SHALL have port cp0_pcout, input, 32, EPC value from CP0 used as the ERET target.
REQ-010 SHALL have ports equal, bneorbeq, branch, jump, isjr, iseret, iscop0, hasexp: each input, 1 bit.
- equal: operands equal.
- bneorbeq: 1 = BNE, 0 = BEQ.
- branch: branch instruction.
- jump: J instruction.
- isjr: JR instruction.
- iseret: ERET instruction.
- iscop0: COP0-class instruction.
- hasexp: exception pending.
REQ-011 SHALL have port final_pc, output, 32, next-PC value; the caller registers it.

Function
REQ-012 SHALL form pc_plus4 = present_pc + 4, modulo 2^32; 32'hFFFFFFFC wraps to 0.
REQ-013 SHALL set branch_taken = branch & (equal ^ bneorbeq).
REQ-014 SHALL form branch_target = pc_plus4 + (extend_inst << 2), modulo 2^32.
- A negative offset SHALL move the target backward.
REQ-015 SHALL form jump_target = {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-016 SHALL compute final_pc combinationally from the inputs; no cycle of latency.
REQ-017 SHALL select final_pc by fixed priority, highest first:
1. boot flag -> RESET_VECTOR.
2. hasexp -> EXC_VECTOR.
3. iseret & iscop0 -> cp0_pcout.
4. isjr -> regfile_r1.
5. jump -> jump_target.
6. branch_taken -> branch_target.
7. Otherwise -> pc_plus4.
REQ-018 SHALL treat iseret without iscop0 as no ERET; selection falls to lower priorities.
REQ-019 SHALL resolve simultaneous control inputs only by the REQ-017 priority; no error is flagged.
REQ-020 SHALL select pc_plus4 when branch=1 but the branch is not taken.

Reset
REQ-021 SHALL hold a 1-bit boot flag register.
- Set at any rising clk edge where rst=1.
- Cleared at the first rising edge where rst=0.
REQ-022 SHALL drive final_pc = RESET_VECTOR while the boot flag is set, regardless of other inputs.
REQ-023 SHALL behave the same when rst is asserted mid-operation: the next edge forces the boot flag to 1.
- The in-flight selection is discarded.

Configuration
REQ-024 SHALL support the macro PC_ALIGN_EN.
- When defined: final_pc[1:0] is forced to 2'b00 for the JR and ERET targets.
- When undefined: those targets pass through unmodified.

Structure
REQ-025 SHALL place RESET_VECTOR and EXC_VECTOR defaults, the PC increment constant 4, and the next-PC source-select enum in shared package pc_pkg.
REQ-026 SHALL implement the branch_target adder as sub-module pc_branch_adder, instantiated once.

Verification
REQ-027 SHALL cover the following directed scenarios:
- Sequential: boot clear, all controls 0, present_pc=0x0 -> final_pc=0x4; after 0x4 -> 0x8.
- Jump: present_pc=0x8, jump=1, instr=0x0800000A -> final_pc=0x28.
- Branch: present_pc=0x10, branch=1, equal=1, bneorbeq=0, extend_inst=0x4 -> final_pc=0x24.
  - Same with bneorbeq=1 -> final_pc=0x14.
- Exception and ERET: hasexp=1 with jump=1 -> final_pc=0x80.
  - iseret=1, iscop0=1, cp0_pcout=0x400 -> final_pc=0x400.
  - iseret=1, iscop0=0 -> final_pc=pc_plus4.
- JR: isjr=1, regfile_r1=0x20 -> 0x20.
  - With regfile_r1=0x23: final_pc=0x20 with PC_ALIGN_EN defined, 0x23 without.
- Reset: rst=1 for one edge with jump=1 -> final_pc=0x0 until the first edge with rst=0, then normal selection.
  - present_pc=0xFFFFFFFC, no controls -> final_pc=0x0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared constants and next-PC source select for the PC unit.
// Holds vector defaults, increment step and the select enum.
package pc_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_DEFAULT   = 32'h0000_0080;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_EXC,
    SEL_ERET,
    SEL_JR,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_SEQ
  } pc_sel_e;

endpackage

// File: rtl/pc_branch_adder.sv
// Branch target adder: pc_plus4 + (word offset << 2), modulo 2^32.
// Ports: pc_plus4, offset (sign-extended words) -> target.
module pc_branch_adder (
  input  logic [31:0] pc_plus4,
  input  logic [31:0] offset,
  output logic [31:0] target
);

  logic unused_hi;
  assign unused_hi = ^offset[31:30];

  assign target = pc_plus4 + {offset[29:0], 2'b00};

endmodule

// File: rtl/pc.sv
// Next-PC select: boot, exception, ERET, JR, J, branch, pc+4.
// Ports: clk, rst, pc/operand inputs, control flags -> final_pc.
// Macro PC_ALIGN_EN clears bits [1:0] of JR and ERET targets.
module pc
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = PC_RESET_DEFAULT,
  parameter logic [31:0] EXC_VECTOR   = PC_EXC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] present_pc,
  input  logic [31:0] extend_inst,
  input  logic [31:0] instr,
  input  logic [31:0] regfile_r1,
  input  logic [31:0] cp0_pcout,
  input  logic        equal,
  input  logic        bneorbeq,
  input  logic        branch,
  input  logic        jump,
  input  logic        isjr,
  input  logic        iseret,
  input  logic        iscop0,
  input  logic        hasexp,
  output logic [31:0] final_pc
);

  logic        boot_q;
  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] eret_tgt;
  logic        br_taken;
  pc_sel_e     sel;

  // Boot flag follows rst: set on any rst edge,
  // cleared on the first edge with rst low.
  always_ff @(posedge clk) begin
    boot_q <= rst;
  end

  assign pc_plus4 = present_pc + PC_INC;
  assign br_taken = branch & (equal ^ bneorbeq);
  assign j_tgt    = {pc_plus4[31:28],
                     instr[25:0], 2'b00};

  pc_branch_adder u_badd (
    .pc_plus4 (pc_plus4),
    .offset   (extend_inst),
    .target   (br_tgt)
  );

`ifdef PC_ALIGN_EN
  assign jr_tgt   = {regfile_r1[31:2], 2'b00};
  assign eret_tgt = {cp0_pcout[31:2], 2'b00};
`else
  assign jr_tgt   = regfile_r1;
  assign eret_tgt = cp0_pcout;
`endif

  logic unused_bits;
  assign unused_bits = ^{instr[31:26],
                         regfile_r1[1:0],
                         cp0_pcout[1:0]};

  // Fixed priority; overlapping controls are legal.
  always_comb begin
    sel = SEL_SEQ;
    if (boot_q)
      sel = SEL_RESET;
    else if (hasexp)
      sel = SEL_EXC;
    else if (iseret && iscop0)
      sel = SEL_ERET;
    else if (isjr)
      sel = SEL_JR;
    else if (jump)
      sel = SEL_JUMP;
    else if (br_taken)
      sel = SEL_BRANCH;
  end

  always_comb begin
    final_pc = pc_plus4;
    unique case (sel)
      SEL_RESET:  final_pc = RESET_VECTOR;
      SEL_EXC:    final_pc = EXC_VECTOR;
      SEL_ERET:   final_pc = eret_tgt;
      SEL_JR:     final_pc = jr_tgt;
      SEL_JUMP:   final_pc = j_tgt;
      SEL_BRANCH: final_pc = br_tgt;
      default:    final_pc = pc_plus4;
    endcase
  end

endmodule

// File: tb/tb_pc.sv
// Scoreboard bench for pc: driver pushes model results,
// monitor pops and compares on each falling edge.
module tb_pc;

  logic        clk;
  logic        rst;
  logic [31:0] present_pc;
  logic [31:0] extend_inst;
  logic [31:0] instr;
  logic [31:0] regfile_r1;
  logic [31:0] cp0_pcout;
  logic        equal;
  logic        bneorbeq;
  logic        branch;
  logic        jump;
  logic        isjr;
  logic        iseret;
  logic        iscop0;
  logic        hasexp;
  logic [31:0] final_pc;

  int          checks;
  int          errors;
  logic        boot_m;
  logic [31:0] exp_q[$];
  string       name_q[$];

  pc dut (
    .clk         (clk),
    .rst         (rst),
    .present_pc  (present_pc),
    .extend_inst (extend_inst),
    .instr       (instr),
    .regfile_r1  (regfile_r1),
    .cp0_pcout   (cp0_pcout),
    .equal       (equal),
    .bneorbeq    (bneorbeq),
    .branch      (branch),
    .jump        (jump),
    .isjr        (isjr),
    .iseret      (iseret),
    .iscop0      (iscop0),
    .hasexp      (hasexp),
    .final_pc    (final_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the next-PC rules written out directly.
  function automatic logic [31:0] model();
    logic [31:0] nxt;
    logic [31:0] t;
    nxt = present_pc + 32'd4;
    if (boot_m) return 32'h0;
    if (hasexp) return 32'h80;
    if (iseret && iscop0) begin
      t = cp0_pcout;
`ifdef PC_ALIGN_EN
      t = t & 32'hFFFF_FFFC;
`endif
      return t;
    end
    if (isjr) begin
      t = regfile_r1;
`ifdef PC_ALIGN_EN
      t = t & 32'hFFFF_FFFC;
`endif
      return t;
    end
    if (jump)
      return (nxt & 32'hF000_0000) |
             ((instr & 32'h03FF_FFFF) * 4);
    if (branch && (equal != bneorbeq))
      return nxt + extend_inst * 4;
    return nxt;
  endfunction

  // ctl = {equal,bneorbeq,branch,jump,isjr,iseret,iscop0,hasexp}
  task automatic drive(input string nm,
                       input logic r,
                       input logic [31:0] ppc,
                       input logic [31:0] ext,
                       input logic [31:0] ins,
                       input logic [31:0] r1,
                       input logic [31:0] epc,
                       input logic [7:0] ctl);
    @(posedge clk);
    boot_m = rst;
    #1;
    rst         = r;
    present_pc  = ppc;
    extend_inst = ext;
    instr       = ins;
    regfile_r1  = r1;
    cp0_pcout   = epc;
    {equal, bneorbeq, branch, jump,
     isjr, iseret, iscop0, hasexp} = ctl;
    exp_q.push_back(model());
    name_q.push_back(nm);
  endtask

  task automatic expect_val(input string nm,
                            input logic [31:0] v);
    // Directed cases also pin the model to a constant.
    logic [31:0] m;
    m = exp_q[$];
    checks++;
    if (m !== v) begin
      errors++;
      $display("FAIL model_%s got=%h want=%h", nm, m, v);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    string       n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (final_pc !== e) begin
        errors++;
        $display("FAIL %s final_pc=%h expected=%h",
                 n, final_pc, e);
      end
    end
  end

  initial begin
    logic [31:0] j23;
    logic [15:0] off;
    logic [7:0]  c;
    logic        r;
    int          wait_cyc;
    checks = 0;
    errors = 0;
    boot_m = 1'b1;
    rst = 1'b1;
    present_pc = '0; extend_inst = '0; instr = '0;
    regfile_r1 = '0; cp0_pcout = '0;
    {equal, bneorbeq, branch, jump,
     isjr, iseret, iscop0, hasexp} = '0;

    drive("boot0", 1, 32'h8, 0, 32'h0800000A, 0, 0,
          8'b0001_0000);
    expect_val("boot0", 32'h0);
    drive("boot1", 0, 32'h8, 0, 32'h0800000A, 0, 0,
          8'b0001_0000);
    expect_val("boot1", 32'h0);
    drive("jump", 0, 32'h8, 0, 32'h0800000A, 0, 0,
          8'b0001_0000);
    expect_val("jump", 32'h28);
    drive("seq0", 0, 32'h0, 0, 0, 0, 0, 8'h00);
    expect_val("seq0", 32'h4);
    drive("seq4", 0, 32'h4, 0, 0, 0, 0, 8'h00);
    expect_val("seq4", 32'h8);
    drive("beq", 0, 32'h10, 32'h4, 0, 0, 0,
          8'b1010_0000);
    expect_val("beq", 32'h24);
    drive("bne", 0, 32'h10, 32'h4, 0, 0, 0,
          8'b1110_0000);
    expect_val("bne", 32'h14);
    drive("bback", 0, 32'h100, 32'hFFFF_FFFC, 0, 0, 0,
          8'b1010_0000);
    expect_val("bback", 32'hF4);
    drive("exc", 0, 32'h10, 0, 32'h0800000A, 0, 0,
          8'b0001_0001);
    expect_val("exc", 32'h80);
    drive("eret", 0, 32'h10, 0, 0, 0, 32'h400,
          8'b0000_0110);
    expect_val("eret", 32'h400);
    drive("eret_nocop", 0, 32'h10, 0, 0, 0, 32'h400,
          8'b0000_0100);
    expect_val("eret_nocop", 32'h14);
    drive("jr", 0, 32'h10, 0, 0, 32'h20, 0,
          8'b0000_1000);
    expect_val("jr", 32'h20);
    drive("jr23", 0, 32'h10, 0, 0, 32'h23, 0,
          8'b0000_1000);
`ifdef PC_ALIGN_EN
    j23 = 32'h20;
`else
    j23 = 32'h23;
`endif
    expect_val("jr23", j23);
    drive("wrap", 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 8'h00);
    expect_val("wrap", 32'h0);
    drive("midrst", 1, 32'h40, 0, 0, 32'h20, 0,
          8'b0000_1000);
    expect_val("midrst", 32'h44 & 32'h0 | 32'h20);
    drive("midrst1", 0, 32'h40, 0, 0, 32'h20, 0,
          8'b0000_1000);
    expect_val("midrst1", 32'h0);
    drive("midrst2", 0, 32'h40, 0, 0, 32'h20, 0,
          8'b0000_1000);
    expect_val("midrst2", 32'h20);

    for (int i = 0; i < 400; i++) begin
      off = 16'($urandom);
      c   = 8'($urandom);
      if ($urandom_range(0, 3) != 0)
        c[4:0] = c[4:0] & 5'($urandom);
      if ($urandom_range(0, 2) != 0) c[0] = 1'b0;
      r = ($urandom_range(0, 15) == 0);
      drive("rand", r, $urandom & 32'hFFFF_FFFC,
            {{16{off[15]}}, off}, $urandom,
            $urandom, $urandom, c);
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d expected=0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
